// File: rtl/pipe_shifter_pkg.sv
// Shared ALU constants: shift/rotate mode encodings and small elaboration helpers.
package pipe_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_SLL = 2'b01,
    MODE_SRL = 2'b10,
    MODE_SRA = 2'b11
  } mode_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MIN_WIDTH     = 4;

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Request/response bundle between a shifter client (master) and pipe_shifter (slave).
interface pipe_shifter_if
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src;
  mode_e            m;
  logic [SHW-1:0]   shamt;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dst;
  logic             zero;

  modport master (
    output in_valid, src, m, shamt, flush, out_ready,
    input  in_ready, out_valid, dst, zero
  );

  modport slave (
    input  in_valid, src, m, shamt, flush, out_ready,
    output in_ready, out_valid, dst, zero
  );

endinterface

// File: rtl/pipe_shifter_shift_stage.sv
// One pipeline stage: conditionally shifts by 2^K and registers data, mode and shift amount.
module shift_stage
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int K     = 0,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  mode_e            i_mode,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_shifted,
  output logic [WIDTH-1:0] o_data,
  output mode_e            o_mode,
  output logic [SHW-1:0]   o_shamt
);

  localparam int DIST = 1 << K;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] r_data;
  mode_e            r_mode;
  logic [SHW-1:0]   r_shamt;

  // SRA uses the current operand's MSB, which earlier stages keep equal to the original sign.
  always_comb begin
    w_shifted = i_data;
    if (i_shamt[K]) begin
      case (i_mode)
        MODE_SLL: w_shifted = i_data << DIST;
        MODE_SRL: w_shifted = i_data >> DIST;
        MODE_SRA: w_shifted = $signed(i_data) >>> DIST;
        default:  w_shifted = (i_data >> DIST) | (i_data << (WIDTH - DIST));
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_mode  <= MODE_ROR;
      r_shamt <= '0;
    end else if (i_load) begin
      r_data  <= w_shifted;
      r_mode  <= i_mode;
      r_shamt <= i_shamt;
    end
  end

  assign o_shifted = w_shifted;
  assign o_data    = r_data;
  assign o_mode    = r_mode;
  assign o_shamt   = r_shamt;

endmodule

// File: rtl/pipe_shifter.sv
// Log-depth shift/rotate pipeline with valid/ready flow control, stall and flush.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  pipe_shifter_if.slave bus
);

  if (!isPow2(WIDTH) || WIDTH < MIN_WIDTH) begin : g_bad_width
    $error("pipe_shifter: WIDTH must be a power of two and at least 4");
  end

  logic             w_stall;
  logic             w_advance;
  logic             w_accept;
  logic [SHW-1:0]   w_vin;
  logic [SHW-1:0]   w_load;
  logic [SHW-1:0]   r_valid;
  logic             r_zero;

  logic [WIDTH-1:0] w_data    [0:SHW];
  mode_e            w_mode    [0:SHW];
  logic [SHW-1:0]   w_shamt   [0:SHW];
  logic [WIDTH-1:0] w_shifted [0:SHW-1];

  assign w_stall      = r_valid[SHW-1] && !bus.out_ready;
  assign w_advance    = !w_stall;
  assign bus.in_ready = !w_stall && !bus.flush;
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign w_vin  = {r_valid[SHW-2:0], w_accept};
  assign w_load = w_vin & {SHW{w_advance && !bus.flush}};

  assign w_data[0]  = bus.src;
  assign w_mode[0]  = bus.m;
  assign w_shamt[0] = bus.shamt;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k),
      .SHW   (SHW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load[k]),
      .i_data    (w_data[k]),
      .i_mode    (w_mode[k]),
      .i_shamt   (w_shamt[k]),
      .o_shifted (w_shifted[k]),
      .o_data    (w_data[k+1]),
      .o_mode    (w_mode[k+1]),
      .o_shamt   (w_shamt[k+1])
    );
  end

  // Flush wins over stall; a stalled pipe freezes valids and the zero flag together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_zero  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_zero  <= 1'b0;
    end else if (w_advance) begin
      r_valid <= w_vin;
      r_zero  <= w_vin[SHW-1] && (w_shifted[SHW-1] == '0);
    end
  end

  assign bus.out_valid = r_valid[SHW-1];
  assign bus.dst       = w_data[SHW];
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_pipe_shifter.sv
// Randomised and directed scoreboard bench for pipe_shifter at WIDTH=16.
module tb_pipe_shifter;
  import pipe_shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             zero;
  } expect_t;

  logic clk;
  logic rst_n;

  pipe_shifter_if #(.WIDTH(WIDTH)) busIf ();

  pipe_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf.slave)
  );

  int               errors = 0;
  int               checks = 0;
  expect_t          scoreQ[$];
  logic             dirValid = 1'b0;
  logic [WIDTH-1:0] dirExp   = '0;

  logic             prevStall = 1'b0;
  logic             prevFlush = 1'b0;
  logic             prevRstN  = 1'b0;
  logic             prevOutValid = 1'b0;
  logic [WIDTH-1:0] prevDst   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: each result bit is picked straight from its source bit position.
  function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] s,
                                                input logic [1:0] md, input int amt);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      case (md)
        2'b01: begin
          j = i - amt;
          if (j >= 0) r[i] = s[j];
          else        r[i] = 1'b0;
        end
        2'b10: begin
          j = i + amt;
          if (j < WIDTH) r[i] = s[j];
          else           r[i] = 1'b0;
        end
        2'b11: begin
          j = i + amt;
          if (j < WIDTH) r[i] = s[j];
          else           r[i] = s[WIDTH-1];
        end
        default: r[i] = s[(i + amt) % WIDTH];
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] s, input mode_e md,
                               input logic [SHW-1:0] amt, input logic hasExp,
                               input logic [WIDTH-1:0] expVal);
    logic ok;
    ok = 1'b0;
    busIf.in_valid = 1'b1;
    busIf.src      = s;
    busIf.m        = md;
    busIf.shamt    = amt;
    dirValid       = hasExp;
    dirExp         = expVal;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = busIf.in_ready && !busIf.flush;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    busIf.in_valid = 1'b0;
    dirValid       = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (scoreQ.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_left", scoreQ.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake, pushes on every acceptance, and checks the control rules.
  always @(negedge clk) begin
    expect_t e;
    logic    expReady;
    expReady = !(busIf.out_valid && !busIf.out_ready) && !busIf.flush;
    checkOutput("in_ready", busIf.in_ready, expReady);
    if (!busIf.out_valid) checkOutput("zero_idle", busIf.zero, 0);
    if (rst_n && prevRstN && prevStall && !prevFlush) begin
      checkOutput("stall_valid", busIf.out_valid, 1);
      checkOutput("stall_dst", busIf.dst, prevDst);
    end
    if (rst_n && prevRstN && !busIf.out_valid)
      checkOutput("dst_hold", busIf.dst, prevDst);
    if (rst_n && busIf.out_valid && busIf.out_ready) begin
      if (scoreQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got dst=0x%0h expected no output", busIf.dst);
      end else begin
        e = scoreQ.pop_front();
        checkOutput("dst", busIf.dst, e.data);
        checkOutput("zero", busIf.zero, e.zero);
      end
    end
    if (busIf.flush) scoreQ.delete();
    if (rst_n && busIf.in_valid && busIf.in_ready && !busIf.flush) begin
      e.data = dirValid ? dirExp : refShift(busIf.src, busIf.m, int'(busIf.shamt));
      e.zero = (e.data == '0);
      scoreQ.push_back(e);
    end
    prevStall    = busIf.out_valid && !busIf.out_ready;
    prevFlush    = busIf.flush;
    prevRstN     = rst_n;
    prevOutValid = busIf.out_valid;
    prevDst      = busIf.dst;
  end

  initial begin
    int lat;
    rst_n           = 1'b0;
    busIf.in_valid  = 1'b0;
    busIf.src       = '0;
    busIf.m         = MODE_ROR;
    busIf.shamt     = '0;
    busIf.flush     = 1'b0;
    busIf.out_ready = 1'b1;
    #12;
    checkOutput("rst_out_valid", busIf.out_valid, 0);
    checkOutput("rst_dst", busIf.dst, 0);
    checkOutput("rst_in_ready", busIf.in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", busIf.in_ready, 1);

    // Single SLL by 15 with latency measurement.
    applyStimulus(16'h0001, MODE_SLL, 4'd15, 1'b1, 16'h8000);
    lat = 1;
    while (!busIf.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, SHW);
    checkOutput("sll15_dst", busIf.dst, 16'h8000);
    waitDrain(30);

    applyStimulus(16'h8000, MODE_SRA, 4'd4,  1'b1, 16'hF800);
    applyStimulus(16'h8000, MODE_SRL, 4'd4,  1'b1, 16'h0800);
    applyStimulus(16'h1234, MODE_ROR, 4'd4,  1'b1, 16'h4123);
    applyStimulus(16'hFFFF, MODE_SRL, 4'd0,  1'b1, 16'hFFFF);
    applyStimulus(16'h00F0, MODE_SLL, 4'd12, 1'b1, 16'h0000);
    applyStimulus(16'hA5C3, MODE_SRA, 4'd0,  1'b1, 16'hA5C3);
    applyStimulus(16'h8001, MODE_ROR, 4'd1,  1'b1, 16'hC000);
    waitDrain(40);

    // Eight back-to-back requests with a three-cycle stall after the first result.
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(16'h0101 * (i + 1), mode_e'(i % 4), 4'(i * 2 + 1), 1'b0, '0);
      end
      begin
        int n;
        n = 0;
        while (!busIf.out_valid && n < 30) begin
          @(posedge clk);
          #1;
          n++;
        end
        busIf.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_in_ready", busIf.in_ready, 0);
          @(posedge clk);
          #1;
        end
        busIf.out_ready = 1'b1;
      end
    join
    waitDrain(60);

    // Flush two in-flight requests, then a fresh one must complete.
    applyStimulus(16'h1111, MODE_SLL, 4'd1, 1'b1, 16'h2222);
    applyStimulus(16'h2222, MODE_SRL, 4'd1, 1'b1, 16'h1111);
    busIf.flush = 1'b1;
    @(posedge clk);
    #1 busIf.flush = 1'b0;
    applyStimulus(16'h0F00, MODE_ROR, 4'd8, 1'b1, 16'h000F);
    waitDrain(30);

    // Asynchronous reset with three operations in flight.
    applyStimulus(16'h1234, MODE_SLL, 4'd3, 1'b0, '0);
    applyStimulus(16'h5678, MODE_SRA, 4'd5, 1'b0, '0);
    applyStimulus(16'h9ABC, MODE_ROR, 4'd7, 1'b0, '0);
    #2 rst_n = 1'b0;
    scoreQ.delete();
    #1;
    checkOutput("midrst_out_valid", busIf.out_valid, 0);
    checkOutput("midrst_dst", busIf.dst, 0);
    checkOutput("midrst_zero", busIf.zero, 0);
    checkOutput("midrst_in_ready", busIf.in_ready, 1);
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_in_ready", busIf.in_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    // Random traffic with random back-pressure and occasional flush.
    for (int c = 0; c < 600; c++) begin
      busIf.in_valid  = ($urandom_range(0, 3) != 0);
      busIf.src       = WIDTH'($urandom);
      busIf.m         = mode_e'($urandom_range(0, 3));
      busIf.shamt     = SHW'($urandom_range(0, WIDTH - 1));
      busIf.out_ready = ($urandom_range(0, 3) != 0);
      busIf.flush     = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    busIf.in_valid  = 1'b0;
    busIf.flush     = 1'b0;
    busIf.out_ready = 1'b1;
    waitDrain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 16; data width; SHALL be a power of two, minimum 4.
REQ-002 Parameter SHW, default $clog2(WIDTH); shift-amount width, derived and not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 src  input  WIDTH  operand.
REQ-008 m  input  2  mode: 01 SLL, 10 SRL, 11 SRA, 00 ROR (rotate right).
REQ-009 shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-010 flush  input  1  synchronous discard of all in-flight operations.
REQ-011 out_valid  output  1  dst/zero hold a completed result.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 dst  output  WIDTH  shifted result.
REQ-014 zero  output  1  dst equals all-zeros.

Function
REQ-015 The block SHALL be a pipeline of SHW registered stages; stage k SHALL apply a shift of 2^k when shamt bit k is set, otherwise pass its operand through.
REQ-016 Each stage SHALL carry valid, data, mode and the remaining shamt bits alongside the data.
REQ-017 A request SHALL be accepted on a cycle with in_valid && in_ready && !flush.
REQ-018 Latency SHALL be exactly SHW cycles: out_valid rises on the SHW-th rising edge after acceptance when there is no stall (WIDTH=16: 4 cycles).
REQ-019 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-020 Stall: when out_valid && !out_ready, every stage SHALL hold its contents and in_ready SHALL be low.
REQ-021 in_ready SHALL equal !(out_valid && !out_ready) && !flush, combinationally.
REQ-022 SLL and SRL SHALL zero-fill; SRA SHALL replicate src[WIDTH-1]; ROR SHALL move bits shifted out of bit 0 into bit WIDTH-1.
REQ-023 shamt = 0 SHALL return src unchanged in every mode.
REQ-024 zero SHALL be registered with dst in the last stage and SHALL be 0 whenever out_valid is 0.
REQ-025 dst SHALL hold its last value while out_valid is low; only out_valid qualifies it.
REQ-026 flush SHALL clear every stage valid on the next edge, override stall, and block acceptance that cycle.
REQ-027 flush asserted with out_valid && out_ready SHALL still clear; the presented result counts as consumed.
REQ-028 Bubbles (cycles with no acceptance) SHALL propagate as invalid stages and SHALL not stall accepted work.

Reset
REQ-029 On rst_n low, all stage valids, out_valid and zero SHALL clear to 0 immediately and dst and all stage data SHALL clear to 0.
REQ-030 in_ready SHALL be 1 while in reset and on the first edge after release (given flush low).
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after release.

Structure
REQ-032 Mode encodings (MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR) SHALL live in the shared ALU constants package, used by the ALU and this block.
REQ-033 One sub-module shift_stage SHALL implement one stage, parametrised by WIDTH and stage index k (shift distance 2^k), instantiated SHW times via generate.
REQ-034 Stall/valid control SHALL reside in pipe_shifter, not in shift_stage.

Verification (WIDTH=16)
REQ-035 SLL src=0x0001 shamt=15 -> dst=0x8000, zero=0, out_valid 4 cycles after accept.
REQ-036 SRA src=0x8000 shamt=4 -> 0xF800; SRL same -> 0x0800; ROR src=0x1234 shamt=4 -> 0x4123; SRL src=0xFFFF shamt=0 -> 0xFFFF.
REQ-037 SLL src=0x00F0 shamt=12 -> dst=0x0000, zero=1.
REQ-038 Back-to-back 8 requests, out_ready low for 3 cycles after first result -> in_ready low during stall, all 8 results in order, none lost or duplicated.
REQ-039 Two requests in flight, flush one cycle -> out_valid never rises for them; a request accepted the next cycle completes normally.
REQ-040 rst_n pulsed low with 3 operations in flight -> out_valid=0 and dst=0 immediately; no result emerges after release; in_ready=1.
